spi_mfrc522_slave: RTL
======================

Name: spi_mfrc522_slave

Overview:
Synthesizable SPI mode-0 slave implementing the MFRC522 register-access protocol: a 64-entry register file, a 64-byte FIFO behind FIFODataReg, and a read-only VersionReg.
It is the responder end of the SPI link driven by spi_axi_controller. It serves as the on-FPGA stand-in for the RFID chip in SoC bring-up and loopback.
All SPI inputs are oversampled in the system clock domain; there is no SCK clock domain.

Parameters:
VERSION, 8'h92, value returned by VersionReg (0x37)
FIFO_DEPTH, 64, FIFO entries (power of two, max 64)
SYNC_STAGES, 2, synchronizer flops on cs_n/sck/mosi (>=2)

Ports:
axi_aclk  input  1  system clock
axi_aresetn  input  1  reset
cs_n  input  1  SPI chip select, active low, asynchronous to axi_aclk
sck  input  1  SPI clock, CPOL=0
mosi  input  1  SPI data in, sampled on SCK rising edge
miso  output  1  SPI data out, changes after SCK falling edge
miso_oe  output  1  1 while cs_n is low (synchronized); pad tristate enable
cmd_valid  output  1  one-cycle pulse on every CommandReg write
cmd_code  output  4  CommandReg[3:0], held until next write
fifo_level  output  7  current FIFO occupancy, 0..64
irq  output  1  FIFO water-level interrupt; see Optional Feature

Behaviour:
- Reset: one clock domain (axi_aclk). Reset is synchronous, active-low (axi_aresetn). Reset values:
  - miso=0, miso_oe=0, cmd_valid=0, cmd_code=0, fifo_level=0, irq=0.
  - Register file all 0; FIFO empty; FSM in IDLE.
- Reset asserted mid-transfer aborts the frame. The FSM stays in IDLE until the next cs_n falling edge.
- Sync: cs_n/sck/mosi each pass through SYNC_STAGES flops. Edges are detected from the last two stages.
- Requirement: SCK high and low times >= 4 axi_aclk periods each.
- Frame format:
  - Byte 0 is the address byte: bit7=1 read / 0 write, bits6:1 = reg addr, bit0 ignored.
  - Bits are MSB first, 8 rising-edge samples per byte.
- FSM states:
  - IDLE -> ADDR on cs_n falling.
  - ADDR -> WDATA (write) or RDATA (read) after the 8th sample.
  - WDATA/RDATA loop per byte.
  - Any state -> IDLE on cs_n rising. A partial byte is discarded: no register write, no FIFO push.
- Write frame: every complete data byte writes the same address. This gives FIFO streaming via repeated 0x09 bytes.
- Read frame:
  - At the end of the address byte, read data for addr is loaded into the TX shifter. Its MSB appears on miso after the following SCK falling edge, before the next rising edge.
  - Each subsequent MOSI byte is the next address. Its data is loaded the same way.
  - A trailing 0x00 byte terminates the frame.
  - MISO during the address byte is 0.
- TX shift: shift on each synchronized SCK falling edge. miso=0 while cs_n high.
- Special registers:
  - 0x01 CommandReg:
    - Write stores [3:0], updates cmd_code, and pulses cmd_valid one cycle after the byte completes.
    - Value 0xF (SoftReset) additionally clears the register file and FIFO in that same cycle. The in-flight frame continues.
    - Read returns {4'b0, cmd_code}.
  - 0x06 ErrorReg: bit4 BufferOvfl is set on a push to a full FIFO. Write of any value clears it.
  - 0x09 FIFODataReg:
    - Write pushes; a push when full is dropped and sets BufferOvfl.
    - Read pops at TX-load time. Read when empty returns 0x00 with no pop.
  - 0x0A FIFOLevelReg: read returns {1'b0, fifo_level}. Write with bit7=1 flushes the FIFO and clears BufferOvfl.
  - 0x0B WaterLevelReg: plain RW, [5:0] used.
  - 0x37 VersionReg: read returns VERSION; writes ignored.
  - All other addresses are plain 8-bit RW.
- FIFO: circular buffer with wrap-around pointers. A same-cycle push and pop cannot occur, since one byte event occurs per cycle.

Optional Feature:
MFRC522_SLAVE_FIFO_IRQ_EN
- Defined: irq is registered and equals (fifo_level >= WaterLevelReg[5:0]) && ComIEnReg(0x02)[0]. It updates one cycle after the level or either register changes.
- Undefined: irq is tied 0 and no comparator logic is built.

Test Plan:
- Write frame {0x12,0xAB} (addr 0x09, write), then read frame {0x92,0x00} -> miso byte1=0xAB; fifo_level 1->0.
- Read frame {0xEE,0x00} (0x37) -> 0x92. Then write {0x6E,0x55} followed by re-read -> still 0x92.
- Write {0x02,0x0F} -> cmd_valid pulses once, cmd_code=0xF; FIFO flushed; a previously written reg 0x0B reads 0x00.
- 65 writes of 0x09 in one frame (data 0..64) -> fifo_level=64; ErrorReg reads 0x10; 64 pops return 0..63; a 65th pop returns 0x00 with level 0.
- Write {0x12} plus 5 bits, then cs_n rises -> fifo_level stays 0. The next full frame decodes correctly.
- axi_aresetn low mid data byte -> all outputs reset values. With MFRC522_SLAVE_FIFO_IRQ_EN, WaterLevel=2 and ComIEn[0]=1: irq rises after the 2nd push and falls after a pop leaves level 1.

Source files
------------

// File: rtl/spi_mfrc522_slave.sv
// SPI mode-0 slave speaking the MFRC522 register protocol: 64-entry register file, FIFO behind 0x09, VersionReg at 0x37.
// Optional build macro MFRC522_SLAVE_FIFO_IRQ_EN enables the registered FIFO water-level irq; otherwise irq is tied low.
module spi_mfrc522_slave #(
  parameter logic [7:0] VERSION     = 8'h92,
  parameter int         FIFO_DEPTH  = 64,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       cs_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic [6:0] fifo_level,
  output logic       irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [5:0] A_CMD = 6'h01, A_ERR = 6'h06, A_FIFO = 6'h09,
                         A_LVL = 6'h0A, A_WL  = 6'h0B, A_VER  = 6'h37;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;
  state_t state_q, state_d;

  // Synchronizers carry no reset so a reset mid-frame cannot fabricate a cs_n edge.
  logic [SYNC_STAGES-1:0] cs_s, sck_s, mosi_s;
  always_ff @(posedge axi_aclk) begin
    cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
    sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
    mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
  end

  logic cs_fall, cs_rise, cs_act, sck_rise, sck_fall;
  assign cs_fall  =  cs_s[SYNC_STAGES-1]  & ~cs_s[SYNC_STAGES-2];
  assign cs_rise  = ~cs_s[SYNC_STAGES-1]  &  cs_s[SYNC_STAGES-2];
  assign cs_act   = ~cs_s[SYNC_STAGES-1];
  assign sck_rise = ~sck_s[SYNC_STAGES-1] &  sck_s[SYNC_STAGES-2];
  assign sck_fall =  sck_s[SYNC_STAGES-1] & ~sck_s[SYNC_STAGES-2];

  logic [2:0]    bit_cnt;
  logic [7:0]    rx_q, tx_q, rx_byte, rd_data;
  logic [5:0]    waddr_q, ld_addr;
  logic          byte_done, wr_en, ld_en, ld_zero, addr_latch, push, pop, full, ovfl_q;
  logic [7:0]    regs [64];
  logic [7:0]    mem  [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [6:0]    count;

  assign rx_byte    = {rx_q[6:0], mosi_s[SYNC_STAGES-1]};
  assign byte_done  = sck_rise && (bit_cnt == 3'd7);
  assign ld_addr    = rx_byte[6:1];
  assign full       = (count == 7'(FIFO_DEPTH));
  assign push       = wr_en && (waddr_q == A_FIFO) && !full;
  assign pop        = ld_en && !ld_zero && (ld_addr == A_FIFO) && (count != 7'd0);
  assign fifo_level = count;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    ld_en      = 1'b0;
    ld_zero    = 1'b0;
    addr_latch = 1'b0;
    if (cs_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:  if (cs_fall) state_d = ADDR;
        ADDR:  if (byte_done) begin
                 addr_latch = 1'b1;
                 ld_en      = rx_byte[7];
                 state_d    = rx_byte[7] ? RDATA : WDATA;
               end
        WDATA: wr_en = byte_done;
        RDATA: if (byte_done) begin
                 ld_en   = 1'b1;
                 ld_zero = (rx_byte == 8'h00);
               end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    case (ld_addr)
      A_CMD:   rd_data = {4'b0, cmd_code};
      A_ERR:   rd_data = {3'b0, ovfl_q, 4'b0};
      A_FIFO:  rd_data = (count != 7'd0) ? mem[rptr] : 8'h00;
      A_LVL:   rd_data = {1'b0, count};
      A_VER:   rd_data = VERSION;
      default: rd_data = regs[ld_addr];
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (push) mem[wptr] <= rx_byte;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      bit_cnt <= '0; rx_q <= '0; tx_q <= '0; miso <= 1'b0; miso_oe <= 1'b0;
      waddr_q <= '0; cmd_valid <= 1'b0; cmd_code <= '0; ovfl_q <= 1'b0;
      wptr <= '0; rptr <= '0; count <= '0;
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else begin
      miso_oe   <= cs_act;
      cmd_valid <= 1'b0;
      if (state_q == IDLE) bit_cnt <= '0;
      else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_q    <= rx_byte;
      end
      // Loaded byte's MSB goes out on the next falling edge, ahead of the master's sample.
      if (!cs_act) begin
        tx_q <= '0;
        miso <= 1'b0;
      end else if (ld_en) tx_q <= ld_zero ? 8'h00 : rd_data;
      else if (sck_fall) begin
        miso <= tx_q[7];
        tx_q <= {tx_q[6:0], 1'b0};
      end
      if (addr_latch) waddr_q <= ld_addr;
      if (push) begin
        wptr  <= wptr + AW'(1);
        count <= count + 7'd1;
      end
      if (pop) begin
        rptr  <= rptr + AW'(1);
        count <= count - 7'd1;
      end
      if (wr_en) begin
        case (waddr_q)
          A_CMD: begin
            cmd_code  <= rx_byte[3:0];
            cmd_valid <= 1'b1;
            if (&rx_byte[3:0]) begin
              for (int i = 0; i < 64; i++) regs[i] <= '0;
              wptr <= '0; rptr <= '0; count <= '0; ovfl_q <= 1'b0;
            end
          end
          A_ERR:  ovfl_q <= 1'b0;
          A_FIFO: if (full) ovfl_q <= 1'b1;
          A_LVL:  if (rx_byte[7]) begin
                    wptr <= '0; rptr <= '0; count <= '0; ovfl_q <= 1'b0;
                  end
          A_WL:   regs[A_WL] <= {2'b00, rx_byte[5:0]};
          A_VER:  ;
          default: regs[waddr_q] <= rx_byte;
        endcase
      end
    end
  end

`ifdef MFRC522_SLAVE_FIFO_IRQ_EN
  localparam logic [5:0] A_COMIEN = 6'h02;
  logic irq_q;
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) irq_q <= 1'b0;
    else              irq_q <= (count >= {1'b0, regs[A_WL][5:0]}) && regs[A_COMIEN][0];
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule
